// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a one-byte holding register; frames run back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_transmit #(
  parameter int BAUD_DIV = 5208,
  parameter int WIDTH    = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_en,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       hold_reg, hold_next;
  logic             hold_valid_reg, hold_valid_next;
  logic             tx_reg, tx_next;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  assign bit_end = (baud_cnt_reg == WIDTH'(BAUD_DIV - 1));
  assign ready   = !hold_valid_reg;
  assign busy    = (state_reg != IDLE);
  assign tx      = tx_reg;

  always_comb begin
    state_next      = state_reg;
    baud_cnt_next   = '0;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    tx_next         = tx_reg;
`ifdef UART_TX_PARITY_EN
    parity_next     = parity_reg;
`endif

    if (state_reg != IDLE && !bit_end)
      baud_cnt_next = baud_cnt_reg + WIDTH'(1);

    // Accept never collides with a transfer: ready is low whenever hold is full.
    if (data_en && !hold_valid_reg) begin
      hold_next       = data_in;
      hold_valid_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (hold_valid_reg) begin
          shift_next      = hold_reg;
          hold_valid_next = 1'b0;
          tx_next         = 1'b0;
          state_next      = START;
`ifdef UART_TX_PARITY_EN
          parity_next     = ^hold_reg;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = parity_reg;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // A queued byte starts its frame on this very edge, leaving no idle gap.
          if (hold_valid_reg) begin
            shift_next      = hold_reg;
            hold_valid_next = 1'b0;
            tx_next         = 1'b0;
            state_next      = START;
`ifdef UART_TX_PARITY_EN
            parity_next     = ^hold_reg;
`endif
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      baud_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      tx_reg         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      baud_cnt_reg   <= baud_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      tx_reg         <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg     <= parity_next;
`endif
    end
  end

endmodule

// File: doc/uart_transmit.md
Name: uart_transmit

Overview:
- Serialises 8-bit parallel bytes onto a UART tx line: 8N1 format, LSB first, idle-high.
- Transmit-side counterpart of the team's 3x-oversampling UART receiver; shares the 50 MHz clk and the same baud rate.
- Includes a one-byte holding register so the upstream logic (e.g. the CRC result path) can queue the next byte while the current frame shifts out. Frames go back-to-back with no idle gap.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit: clk/baudrate, i.e. 50 MHz / 9600.
- WIDTH, 13, bit counter width. Must satisfy 2^WIDTH > BAUD_DIV-1.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  synchronous, active-low reset
- data_en  input  1  byte valid strobe
- data_in  input  8  byte to transmit; sampled when data_en && ready
- ready  output  1  holding register empty; a byte is accepted this cycle if data_en=1
- busy  output  1  a frame is in progress (state != IDLE)
- tx  output  1  UART serial output, registered

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - tx=1, busy=0, ready=1 (holding register cleared), state=IDLE.
  - Baud counter and bit counter cleared.
  - Applies mid-frame too: the partial frame is truncated, and tx returns high at that edge.
- Handshake:
  - Accept on a rising edge where data_en=1 and ready=1. data_in is loaded into the holding register and hold_valid is set.
  - ready = !hold_valid, driven from a register; there is no combinational path from data_en.
  - If data_en=1 while ready=0, the byte is silently dropped. No error flag.
- States: IDLE, START, DATA, STOP.
  - Each of START, DATA (per bit) and STOP lasts exactly BAUD_DIV cycles.
  - The baud counter counts 0..BAUD_DIV-1, and the bit time ends on the edge where it equals BAUD_DIV-1.
- IDLE: tx=1. If hold_valid=1 at an edge:
  - Move hold to the shift register and clear hold_valid.
  - tx<=0, state<=START, baud counter<=0.
- START: at end of bit time:
  - state<=DATA, bit index<=0, tx<=shift[0].
- DATA: at end of each bit time:
  - Shift right.
  - If bit index==7: tx<=1, state<=STOP.
  - Otherwise: bit index+1 and tx<=next bit.
- STOP: at end of bit time:
  - If hold_valid=1: reload the shift register from hold, clear hold_valid, tx<=0, state<=START. This gives a back-to-back frame with no extra idle cycles.
  - Otherwise: state<=IDLE, tx stays 1.
- Latency: a byte accepted at edge k while IDLE sees tx fall at edge k+1. Frame length is 10*BAUD_DIV cycles.
- Holding register accept and transfer are mutually exclusive by construction, because ready=0 whenever hold_valid=1. ready rises at the edge where the transfer occurs.
- busy=1 from the START entry edge through the end of STOP, and drops on the IDLE entry edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, lasting BAUD_DIV cycles.
  - tx carries even parity (XOR of the 8 data bits) during that state.
  - Frame length becomes 11*BAUD_DIV cycles.
- When undefined: no PARITY state or logic; 8N1 framing exactly as above.

Test Plan:
- BAUD_DIV=4; reset, then hold data_en=0 for 20 cycles -> tx=1, ready=1, busy=0 throughout.
- BAUD_DIV=4; send 0x55 at edge k:
  - tx=0 during cycles k+1..k+4.
  - Then 1,0,1,0,1,0,1,0, each for 4 cycles.
  - Then stop=1 for 4 cycles.
  - busy falls at k+41.
- BAUD_DIV=4; send 0xA3, then 0x3C as soon as ready=1 -> second start bit begins at the same edge the first stop bit ends (0 idle cycles). Decoded bytes are 0xA3, 0x3C.
- Backpressure: send 0x11 and 0x22, then assert data_en with 0x33 while ready=0 -> only 0x11 and 0x22 appear on tx; 0x33 is never sent.
- Mid-frame reset: rst_n=0 for 1 cycle during bit 3 of 0xF0 -> tx=1 at that edge, ready=1, busy=0. A following 0x81 is transmitted correctly.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit=1. Send 0x03 -> parity bit=0. Each frame is 44 cycles at BAUD_DIV=4.
